auth_msg_tx_serializer: RTL



---
 rtl/auth_msg_tx_serializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/auth_msg_tx_serializer.sv
// Captures a certificate response (or a bare error header) and streams it out
// one byte per accepted beat; re-arms only after the upstream levels drop.
module auth_msg_tx_serializer #(
  parameter int         PAYLOAD_BYTES = 257,
  parameter logic [7:0] ERR_CMD       = 8'h7F
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       Ack_in,
  input  logic                       Error_in,
  input  logic [31:0]                header_in,
  input  logic [8*PAYLOAD_BYTES-1:0] payload_in,
  input  logic [15:0]                payload_len,
  input  logic                       tx_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_last,
  output logic                       busy,
  output logic                       done,
  output logic                       len_err,
  output logic [1:0]                 state_dbg
);

  // Handshake: a beat transfers on a rising edge where tx_valid & tx_ready;
  // tx_valid, tx_data and tx_last hold while tx_ready is low, and tx_valid
  // never drops inside a message.

  localparam int          PW   = 8 * PAYLOAD_BYTES;
  localparam logic [15:0] PB16 = 16'(PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_HDR = 2'd1,
    SEND_PAY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          arm_q;
  logic [31:0]   hdr_q;
  logic [PW-1:0] pay_q;
  logic [15:0]   count_q;
  logic [15:0]   idx_q;

  logic capture;
  logic len_ovf;
  logic take_err;
  logic beat;
  logic hdr_last_byte;
  logic pay_last_byte;

  assign len_ovf       = (payload_len > PB16);
  assign capture       = (state_q == IDLE) && arm_q && (Ack_in || Error_in);
  assign take_err      = Error_in || len_ovf;
  assign beat          = tx_valid && tx_ready;
  assign hdr_last_byte = (idx_q == 16'd3);
  assign pay_last_byte = (idx_q == (count_q - 16'd1));
  assign state_dbg     = state_q;

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) state_d = SEND_HDR;
      end
      SEND_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_q[31:24];
        tx_last  = hdr_last_byte && (count_q == 16'd0);
        if (beat && hdr_last_byte) state_d = (count_q != 16'd0) ? SEND_PAY : DONE;
      end
      SEND_PAY: begin
        tx_valid = 1'b1;
        tx_data  = pay_q[PW-1 -: 8];
        tx_last  = pay_last_byte;
        if (beat && pay_last_byte) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Header and payload are shift registers: the byte on the wire is always the top byte.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      arm_q   <= 1'b1;
      hdr_q   <= 32'h0;
      pay_q   <= '0;
      count_q <= 16'h0;
      idx_q   <= 16'h0;
      len_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        arm_q   <= 1'b0;
        idx_q   <= 16'h0;
        pay_q   <= payload_in;
        len_err <= !Error_in && len_ovf;
        if (take_err) begin
          hdr_q   <= {header_in[31:24], ERR_CMD, header_in[15:8], 8'h00};
          count_q <= 16'h0;
        end else begin
          hdr_q   <= header_in;
          count_q <= payload_len;
        end
      end else begin
        if ((state_q == IDLE) && !Ack_in && !Error_in) arm_q <= 1'b1;
        if (beat) begin
          if (state_q == SEND_HDR) begin
            hdr_q <= {hdr_q[23:0], 8'h00};
            idx_q <= hdr_last_byte ? 16'h0 : idx_q + 16'd1;
          end else begin
            pay_q <= {pay_q[PW-9:0], 8'h00};
            idx_q <= idx_q + 16'd1;
          end
        end
      end
    end
  end

endmodule
